// File: rtl/sub_bytes_pkg.sv
// AES S-box constant tables and lookup helper shared by the SubBytes engine.
// The inverse table is derived from the forward table at elaboration time.
package sub_bytes_pkg;
  localparam int BYTE_W = 8;

  typedef logic [0:255][BYTE_W-1:0] sbox_t;

  localparam sbox_t SBOX_FWD = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic sbox_t build_inv();
    sbox_t r;
    logic [BYTE_W-1:0] k;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      k = BYTE_W'(i);
      r[SBOX_FWD[k]] = k;
    end
    return r;
  endfunction

  localparam sbox_t SBOX_INV = build_inv();

  function automatic logic [BYTE_W-1:0] sbox_sub(input logic [BYTE_W-1:0] b, input logic dec);
    return dec ? SBOX_INV[b] : SBOX_FWD[b];
  endfunction
endpackage

// File: rtl/sbox_lane.sv
// Single-byte combinational S-box lookup for one lane.
// SUB_BYTES_INV_EN selects between forward/inverse tables; otherwise forward only.
module sbox_lane
  import sub_bytes_pkg::*;
(
  input  logic [BYTE_W-1:0] i_Byte,
  input  logic              i_fDec,
  output logic [BYTE_W-1:0] o_Byte
);
`ifdef SUB_BYTES_INV_EN
  assign o_Byte = sbox_sub(i_Byte, i_fDec);
`else
  logic unused_fdec;
  assign unused_fdec = i_fDec;
  assign o_Byte      = SBOX_FWD[i_Byte];
`endif
endmodule

// File: rtl/sub_bytes_pipe.sv
// Pipelined AES SubBytes/InvSubBytes engine, LANES bytes per beat, valid/ready both sides.
// Define SUB_BYTES_INV_EN to build the inverse table and honour i_fDec.
module sub_bytes_pipe
  import sub_bytes_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 32
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  input  logic [BYTE_W*LANES-1:0] i_Data,
  input  logic                    i_fDec,
  output logic                    o_Valid,
  input  logic                    i_Ready,
  output logic [BYTE_W*LANES-1:0] o_Data,
  output logic                    o_fDec,
  output logic [CNT_W-1:0]        o_Count
);
  localparam int W = BYTE_W * LANES;

  logic [STAGES-1:0]         st_vld;
  logic [STAGES-1:0][W-1:0]  st_dat;
  logic [STAGES-1:0]         st_fd;
  logic [CNT_W-1:0]          cnt;

  // Index 0 is the input port, index s+1 is the output of stage s.
  logic [STAGES:0]           vld;
  logic [STAGES:0][W-1:0]    dat;
  logic [STAGES:0]           fd;
  logic [STAGES-1:0]         rdy;
  logic                      rdy_acc;
  logic                      fd_in;
  logic [W-1:0]              sub;

`ifdef SUB_BYTES_INV_EN
  assign fd_in = i_fDec;
`else
  logic unused_fdec;
  assign unused_fdec = i_fDec;
  assign fd_in       = 1'b0;
`endif

  assign vld = {st_vld, i_Valid};
  assign dat = {st_dat, i_Data};
  assign fd  = {st_fd, fd_in};

  // Stage s may load when any stage downstream of it has a hole, or the sink is taking.
  always_comb begin
    rdy_acc = i_Ready;
    rdy     = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy_acc = rdy_acc || !vld[s+1];
      rdy[s]  = rdy_acc;
    end
  end

  // Lookup sits in front of the last register stage.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sbox_lane u_lane (
      .i_Byte (dat[STAGES-1][BYTE_W*k +: BYTE_W]),
      .i_fDec (fd[STAGES-1]),
      .o_Byte (sub[BYTE_W*k +: BYTE_W])
    );
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      st_vld <= '0;
      st_dat <= '0;
      st_fd  <= '0;
      cnt    <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (rdy[s]) st_vld[s] <= vld[s];
        if (rdy[s] && vld[s]) begin
          st_dat[s] <= (s == STAGES - 1) ? sub : dat[s];
          st_fd[s]  <= fd[s];
        end
      end
      if (vld[STAGES] && i_Ready) cnt <= cnt + 1'b1;
    end
  end

  assign o_Ready = rdy[0];
  assign o_Valid = vld[STAGES];
  assign o_Data  = dat[STAGES];
  assign o_fDec  = fd[STAGES];
  assign o_Count = cnt;
endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Randomized + directed bench for sub_bytes_pipe against a GF(2^8)-derived S-box model.
module tb_sub_bytes_pipe;
  localparam int LANES  = 16;
  localparam int STAGES = 2;
  localparam int CNT_W  = 32;
  localparam int W      = 8 * LANES;
`ifdef SUB_BYTES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, i_valid, o_ready, i_fdec, o_valid, i_ready, o_fdec;
  logic [W-1:0]     i_data, o_data;
  logic [CNT_W-1:0] o_count;

  always #5 clk = ~clk;

  sub_bytes_pipe #(.LANES(LANES), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(i_valid), .o_Ready(o_ready), .i_Data(i_data),
    .i_fDec(i_fdec), .o_Valid(o_valid), .i_Ready(i_ready), .o_Data(o_data),
    .o_fDec(o_fdec), .o_Count(o_count)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---- reference model: S-box from field inversion + affine map ----
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_model();
    logic [7:0] a, r, s;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      r = 8'h01;
      if (a == 8'h00) r = 8'h00;
      else for (int j = 0; j < 253; j++) r = gmul(r, a);
      if (a != 8'h00) r = gmul(r, a) == 8'h01 ? r : gmul(r, a);
      s = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
      fwd_t[i] = s;
      inv_t[s] = a;
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dec);
    logic [W-1:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      b = d[8*k +: 8];
      r[8*k +: 8] = (dec && INV_EN) ? inv_t[b] : fwd_t[b];
    end
    return r;
  endfunction

  // ---- scoreboard / compare process ----
  typedef struct { logic [W-1:0] d; logic f; } beat_t;
  beat_t            q[$];
  beat_t            e;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               delivered = 0;
  logic [W-1:0]     out_log[$];
  logic             flog[$];
  bit               run_chk = 0;
  bit               prev_stall = 0;
  logic [W-1:0]     prev_d;
  logic             prev_f;

  always @(negedge clk) begin
    if (run_chk) begin
      chk("count", W'(o_count), W'(exp_cnt));
      if (o_valid) chk("valid_has_beat", W'(q.size() > 0), W'(1));
      if (prev_stall) begin
        chk("stall_valid", W'(o_valid), W'(1));
        chk("stall_data", o_data, prev_d);
        chk("stall_fdec", W'(o_fdec), W'(prev_f));
      end
      if (rst) begin
        q.delete();
        exp_cnt    = '0;
        prev_stall = 0;
      end else begin
        if (o_valid && i_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("out_data", o_data, e.d);
          chk("out_fdec", W'(o_fdec), W'(e.f));
          exp_cnt = exp_cnt + 1'b1;
          delivered++;
          out_log.push_back(o_data);
          flog.push_back(o_fdec);
        end
        if (i_valid && o_ready) q.push_back('{model(i_data, i_fdec), INV_EN & i_fdec});
        prev_stall = o_valid && !i_ready;
        prev_d     = o_data;
        prev_f     = o_fdec;
      end
    end
  end

  // ---- downstream ready driver: 0 low, 1 high, 2 random, 3 held by main ----
  int rdy_mode = 1;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: i_ready = 1'b0;
      1: i_ready = 1'b1;
      2: i_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic f);
    bit acc;
    int waits = 0;
    i_valid = 1'b1; i_data = d; i_fdec = f;
    forever begin
      @(negedge clk); acc = o_ready;
      @(posedge clk); #1;
      if (acc) break;
      waits++;
      if (waits > 500) begin
        tests++; fails++;
        $display("FAIL send_timeout: got %0d waits expected accept", waits);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_deliv(input int target);
    int t = 0;
    while (delivered < target && t < 2000) begin @(negedge clk); t++; end
    if (delivered < target) begin
      tests++; fails++;
      $display("FAIL deliver_timeout: got %0d expected %0d", delivered, target);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int k, n, base;
  logic [CNT_W-1:0] base_cnt;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_fdec = 1'b0; i_ready = 1'b1;
    build_model();
    chk("model_fwd_00", W'(fwd_t[8'h00]), W'(8'h63));
    chk("model_fwd_53", W'(fwd_t[8'h53]), W'(8'hed));
    chk("model_fwd_ff", W'(fwd_t[8'hff]), W'(8'h16));
    chk("model_inv_ed", W'(inv_t[8'hed]), W'(8'h53));

    repeat (2) @(posedge clk);
    #1 run_chk = 1;
    @(negedge clk);
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_data",  o_data, '0);
    chk("rst_fdec",  W'(o_fdec), W'(0));
    chk("rst_count", W'(o_count), W'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", W'(o_ready), W'(1));

    // 1: all-zero beat, latency and count
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = '0; i_fdec = 1'b0;
    @(posedge clk); #1 i_valid = 1'b0;
    k = 0;
    while (k < 20) begin @(negedge clk); k++; if (o_valid) break; end
    chk("latency", W'(k), W'(STAGES));
    chk("t1_data", o_data, {16{8'h63}});
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_count", W'(o_count), W'(1));
    @(posedge clk); #1;

    // 2: FIPS-197 style vector
    base = delivered;
    send(128'h00112233445566778899aabbccddeeff, 1'b0);
    wait_deliv(base + 1);
    chk("t2_data", out_log[$], 128'h638293c31bfc33f5c4eeacea4bc12816);

    // 3: inverse and mixed modes
    base = delivered;
    send({16{8'h63}}, 1'b1);
    send({16{8'h53}}, 1'b0);
    send({16{8'hed}}, 1'b1);
    wait_deliv(base + 3);
`ifdef SUB_BYTES_INV_EN
    chk("t3_inv63", out_log[base], {16{8'h00}});
    chk("t3_mix_b", out_log[base+2], {16{8'h53}});
    chk("t3_fdec",  W'(flog[base+2]), W'(1));
`else
    chk("t3_inv63", out_log[base], {16{8'hfb}});
    chk("t3_mix_b", out_log[base+2], {16{8'h55}});
    chk("t3_fdec",  W'(flog[base+2]), W'(0));
`endif
    chk("t3_mix_a", out_log[base+1], {16{8'hed}});

    // 4: 20 beats with random back-pressure
    base = delivered; base_cnt = o_count;
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) send(rnd_data(), 1'($urandom_range(0, 1)));
    wait_deliv(base + 20);
    @(negedge clk);
    chk("t4_count", W'(o_count), W'(base_cnt + 20));
    rdy_mode = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // 5: fill with sink blocked, then release for full throughput
    rdy_mode = 3; i_ready = 1'b0;
    n = 0;
    i_valid = 1'b1; i_data = rnd_data(); i_fdec = 1'($urandom_range(0, 1));
    while (n < 10) begin
      @(negedge clk);
      if (!o_ready) break;
      @(posedge clk); #1;
      n++;
      i_data = rnd_data(); i_fdec = 1'($urandom_range(0, 1));
    end
    chk("t5_fill", W'(n), W'(STAGES));
    chk("t5_ready_low", W'(o_ready), W'(0));
    @(posedge clk); #1 i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_thru", W'(o_ready && o_valid), W'(1));
      @(posedge clk); #1;
      i_data = rnd_data(); i_fdec = 1'($urandom_range(0, 1));
    end
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 6: reset with beats in flight
    i_ready = 1'b0;
    send(rnd_data(), 1'b0);
    send(rnd_data(), 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", W'(o_valid), W'(0));
    chk("t6_count", W'(o_count), W'(0));
    @(posedge clk); #1 i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_stale", W'(o_valid), W'(0));
    end
    @(posedge clk); #1;

    // long random soak
    rdy_mode = 2;
    base = delivered;
    for (int i = 0; i < 300; i++) begin
      send(rnd_data(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    wait_deliv(base + 300);
    rdy_mode = 1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
